// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu -- registered WIDTH-bit arithmetic/logic unit.
//
// This block selects one of eight functions of operands A and B using fxn. It
// captures the result into X on the rising clock edge while in_valid is high.
// out_valid shows that X was updated on the most recent rising edge.
//
// Ports:
//   clk       system clock, rising-edge active
//   rst_n     asynchronous active-low reset (clears X, out_valid and flags)
//   A, B      WIDTH-bit operands (two's complement where signedness matters)
//   fxn       function select:
//               000 A, 001 B, 010 -A, 011 -B, 100 signed A<B mask,
//               101 XNOR, 110 A+B, 111 A-B
//   in_valid  operands and fxn are valid this cycle
//   X         registered result
//   out_valid X was captured on the last rising edge
//
// Optional build macro ALU_FLAGS_EN adds the registered flags zero, carry and
// overflow. They are captured together with X.
// -----------------------------------------------------------------------------
module alu #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       fxn,
    input  logic             in_valid,
`ifdef ALU_FLAGS_EN
    output logic             zero,
    output logic             carry,
    output logic             overflow,
`endif
    output logic [WIDTH-1:0] X,
    output logic             out_valid
);

    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    logic [WIDTH-1:0] result_s;
    logic [WIDTH-1:0] x_d;
    logic [WIDTH-1:0] x_q;
    logic             valid_d;
    logic             valid_q;

    // Function decode. Each arm reads only the operands it needs, so an
    // unknown value on an unused operand cannot reach the result.
    always_comb begin
        result_s = ZERO;
        case (fxn)
            3'b000:  result_s = A;
            3'b001:  result_s = B;
            3'b010:  result_s = (~A) + ONE;
            3'b011:  result_s = (~B) + ONE;
            3'b100: begin
                if ($signed(A) < $signed(B)) begin
                    result_s = ALL_ONES;
                end else begin
                    result_s = ZERO;
                end
            end
            3'b101:  result_s = ~(A ^ B);
            3'b110:  result_s = A + B;
            3'b111:  result_s = A - B;
            default: result_s = ZERO;
        endcase
    end

    // Capture control: load a new result on valid cycles, otherwise hold.
    always_comb begin
        valid_d = in_valid;
        if (in_valid) begin
            x_d = result_s;
        end else begin
            x_d = x_q;
        end
    end

`ifdef ALU_FLAGS_EN
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH:0] sum_s;
    logic [WIDTH:0] diff_s;
    logic           carry_s;
    logic           ovf_s;
    logic           zero_d;
    logic           carry_d;
    logic           ovf_d;
    logic           zero_q;
    logic           carry_q;
    logic           ovf_q;

    // Flag derivation. The extra top bit of diff_s is the unsigned borrow.
    always_comb begin
        sum_s   = {1'b0, A} + {1'b0, B};
        diff_s  = {1'b0, A} - {1'b0, B};
        carry_s = 1'b0;
        ovf_s   = 1'b0;
        case (fxn)
            3'b010:  ovf_s = (A == MOST_NEG);
            3'b011:  ovf_s = (B == MOST_NEG);
            3'b110: begin
                carry_s = sum_s[WIDTH];
                ovf_s   = (A[WIDTH-1] == B[WIDTH-1]) &&
                          (sum_s[WIDTH-1] != A[WIDTH-1]);
            end
            3'b111: begin
                carry_s = diff_s[WIDTH];
                ovf_s   = (A[WIDTH-1] != B[WIDTH-1]) &&
                          (diff_s[WIDTH-1] != A[WIDTH-1]);
            end
            default: begin
                carry_s = 1'b0;
                ovf_s   = 1'b0;
            end
        endcase
    end

    // Flags follow the same load/hold rule as X.
    always_comb begin
        if (in_valid) begin
            zero_d  = (result_s == ZERO);
            carry_d = carry_s;
            ovf_d   = ovf_s;
        end else begin
            zero_d  = zero_q;
            carry_d = carry_q;
            ovf_d   = ovf_q;
        end
    end

    // Flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            zero_q  <= zero_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    assign zero     = zero_q;
    assign carry    = carry_q;
    assign overflow = ovf_q;
`else
`endif

    // Result and valid registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q     <= ZERO;
            valid_q <= 1'b0;
        end else begin
            x_q     <= x_d;
            valid_q <= valid_d;
        end
    end

    assign X         = x_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_alu.sv
// -----------------------------------------------------------------------------
// tb_alu -- table-driven self-checking bench for alu (WIDTH = 6).
// Inputs change on the falling edge. Outputs are sampled on the next falling
// edge, or between edges for the asynchronous reset check.
// -----------------------------------------------------------------------------
module tb_alu;

    logic       clk;
    logic       rst_n;
    logic [5:0] a;
    logic [5:0] b;
    logic [2:0] fxn;
    logic       in_valid;
    logic [5:0] x;
    logic       out_valid;
`ifdef ALU_FLAGS_EN
    logic       zero;
    logic       carry;
    logic       overflow;
`endif

    int checks   = 0;
    int failures = 0;

    alu #(.WIDTH(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (a),
        .B         (b),
        .fxn       (fxn),
        .in_valid  (in_valid),
`ifdef ALU_FLAGS_EN
        .zero      (zero),
        .carry     (carry),
        .overflow  (overflow),
`endif
        .X         (x),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] a;
        logic [5:0] b;
        logic [2:0] fxn;
        logic [5:0] x;
        logic       z;
        logic       c;
        logic       o;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    initial begin
        logic [5:0] held;

        // Expected results are worked out by hand. Each unused operand holds
        // a deliberately busy value.
        //                 A          B          fxn      X          z     c     o
        vecs.push_back('{6'b010101, 6'b001100, 3'b000, 6'b010101, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{6'b110011, 6'b101010, 3'b001, 6'b101010, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{6'b000101, 6'b111000, 3'b010, 6'b111011, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{6'b100111, 6'b001010, 3'b011, 6'b110110, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{6'b001000, 6'b010000, 3'b100, 6'b111111, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{6'b100000, 6'b011111, 3'b100, 6'b111111, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{6'b010000, 6'b001000, 3'b100, 6'b000000, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{6'b101010, 6'b110011, 3'b101, 6'b100110, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{6'b001010, 6'b000101, 3'b110, 6'b001111, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{6'b010000, 6'b000101, 3'b111, 6'b001011, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{6'b011111, 6'b000001, 3'b110, 6'b100000, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{6'b000000, 6'b000001, 3'b111, 6'b111111, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{6'b100000, 6'b010101, 3'b010, 6'b100000, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{6'b010101, 6'b010101, 3'b100, 6'b000000, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{6'b111111, 6'b000000, 3'b011, 6'b000000, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{6'b111111, 6'b000001, 3'b100, 6'b111111, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{6'b000001, 6'b111111, 3'b100, 6'b000000, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{6'b100000, 6'b000001, 3'b111, 6'b011111, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{6'b111111, 6'b000001, 3'b110, 6'b000000, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{6'b010110, 6'b100000, 3'b011, 6'b100000, 1'b0, 1'b0, 1'b1});

        rst_n    = 1'b0;
        a        = 6'b000000;
        b        = 6'b000000;
        fxn      = 3'b000;
        in_valid = 1'b0;

        // Reset state
        @(negedge clk);
        check("reset_x", x, 6'b000000);
        check("reset_valid", {5'b00000, out_valid}, 6'b000000);

        // Release with no valid input: nothing should be captured
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_x", x, 6'b000000);
        check("idle_valid", {5'b00000, out_valid}, 6'b000000);

        // Table sweep: in_valid stays high, so the sweep runs back-to-back
        foreach (vecs[i]) begin
            a        = vecs[i].a;
            b        = vecs[i].b;
            fxn      = vecs[i].fxn;
            in_valid = 1'b1;
            @(negedge clk);
            check($sformatf("vec%0d_x", i), x, vecs[i].x);
            check($sformatf("vec%0d_valid", i), {5'b00000, out_valid}, 6'b000001);
`ifdef ALU_FLAGS_EN
            check($sformatf("vec%0d_flags", i), {3'b000, zero, carry, overflow},
                  {3'b000, vecs[i].z, vecs[i].c, vecs[i].o});
`endif
        end

        // Three consecutive valid cycles, each with a different function
        a = 6'b000011; b = 6'b000100; fxn = 3'b110; in_valid = 1'b1;
        @(negedge clk);
        check("b2b0_x", x, 6'b000111);
        check("b2b0_valid", {5'b00000, out_valid}, 6'b000001);
        fxn = 3'b111;
        @(negedge clk);
        check("b2b1_x", x, 6'b111111);
        check("b2b1_valid", {5'b00000, out_valid}, 6'b000001);
        fxn = 3'b101;
        @(negedge clk);
        check("b2b2_x", x, 6'b111000);
        check("b2b2_valid", {5'b00000, out_valid}, 6'b000001);
        held = 6'b111000;

        // in_valid low with new operands: X holds and out_valid drops
        a = 6'b011011; b = 6'b000110; fxn = 3'b000; in_valid = 1'b0;
        @(negedge clk);
        check("hold0_x", x, held);
        check("hold0_valid", {5'b00000, out_valid}, 6'b000000);
        @(negedge clk);
        check("hold1_x", x, held);
        check("hold1_valid", {5'b00000, out_valid}, 6'b000000);

        // Load a nonzero result, then assert reset between clock edges
        a = 6'b010101; fxn = 3'b000; in_valid = 1'b1;
        @(negedge clk);
        check("preload_x", x, 6'b010101);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_x", x, 6'b000000);
        check("async_rst_valid", {5'b00000, out_valid}, 6'b000000);
`ifdef ALU_FLAGS_EN
        check("async_rst_flags", {3'b000, zero, carry, overflow}, 6'b000000);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_x", x, 6'b000000);
        check("post_rst_valid", {5'b00000, out_valid}, 6'b000000);

        // First capture after the reset is released
        a = 6'b001010; b = 6'b000101; fxn = 3'b110; in_valid = 1'b1;
        @(negedge clk);
        check("first_cap_x", x, 6'b001111);
        check("first_cap_valid", {5'b00000, out_valid}, 6'b000001);
        in_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
